// File: rtl/ofifo_pkg.sv
// Shared constants and helpers for the output FIFO row and its column lanes.
package ofifo_pkg;

    localparam int DEPTH = 64;

    function automatic int ofifo_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int PTR_W = ofifo_clog2(DEPTH) + 1;

    // Pointer for a default-depth lane: the MSB is the wrap bit.
    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/fifo_lane.sv
// One column FIFO: a circular buffer with wrap-bit pointers and a combinational head.
module fifo_lane
    import ofifo_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [psum_bw-1:0] din,
    input  logic               pop,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full
);

    localparam int AW = ofifo_clog2(depth);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [psum_bw-1:0] mem [depth];
    logic [AW:0]        wptr;
    logic [AW:0]        rptr;
    logic               push;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    // A full lane still accepts a write when the head leaves on the same edge.
    assign push  = wr & (~full | pop);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ofifo_row.sv
// Re-aligns diagonally skewed MAC column psums into full rows; one FIFO lane per column.
// Optional OFIFO_ROW_OVERFLOW_EN adds sticky per-lane drop flags and a saturating drop count.
module ofifo_row
    import ofifo_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   out_vld
`ifdef OFIFO_ROW_OVERFLOW_EN
    ,
    output logic [col-1:0]         o_ovf,
    output logic [15:0]            o_ovf_cnt
`endif
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [psum_bw*col-1:0] head;
    logic                   pop;

    // Handshake: a row pops on an edge where rd and o_valid are both high
    // (o_valid from pre-edge state); the row appears on out with out_vld one
    // cycle later. o_ready only reports that every lane can take a write.
    assign o_valid = ~|empty;
    assign o_ready = ~|full;
    assign o_full  = |full;
    assign pop     = rd & o_valid;

    for (genvar g = 0; g < col; g++) begin : g_lane
        fifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[g]),
            .din   (in[psum_bw*g +: psum_bw]),
            .pop   (pop),
            .dout  (head[psum_bw*g +: psum_bw]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= pop;
            if (pop) out <= head;
        end
    end

`ifdef OFIFO_ROW_OVERFLOW_EN
    logic [col-1:0] drop;
    logic [16:0]    cnt_sum;

    assign drop    = wr & full & {col{~pop}};
    assign cnt_sum = {1'b0, o_ovf_cnt} + 17'($countones(drop));

    always_ff @(posedge clk) begin
        if (reset) begin
            o_ovf     <= '0;
            o_ovf_cnt <= '0;
        end else begin
            o_ovf     <= o_ovf | drop;
            o_ovf_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end
`endif

endmodule
